// File: rtl/top_level_nios2_qsys_0_mul_seq.sv
// Multi-pass 32x32 multiply sequencer in front of a 32-bit multiply cell.
// Issues 16x16 partial products, accumulates into 64 bits, sign-fixes the high word.
module top_level_nios2_qsys_0_mul_seq #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [2:0] LAT     = 3'(MUL_LATENCY);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [1:0]  pass_q, pass_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] rsp_result_q, rsp_result_d;

  logic [15:0] a_half, b_half;
  logic [63:0] partial;
  logic [31:0] hi_fix;
  logic [1:0]  last_pass;

  // Pass bit 0 picks the A half, bit 1 the B half: p0 AL*BL, p1 AH*BL, p2 AL*BH, p3 AH*BH.
  always_comb begin
    a_half    = pass_q[0] ? a_q[31:16] : a_q[15:0];
    b_half    = pass_q[1] ? b_q[31:16] : b_q[15:0];
    last_pass = (op_q == OP_MUL) ? 2'd2 : 2'd3;
    case (pass_q)
      2'd0:    partial = {32'h0, mul_cell_result};
      2'd3:    partial = {mul_cell_result, 32'h0};
      default: partial = {16'h0, mul_cell_result, 16'h0};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    acc_d        = acc_q;
    pass_d       = pass_q;
    wait_d       = wait_q;
    rsp_result_d = rsp_result_q;
    hi_fix       = acc_q[63:32];
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_src1;
          b_d     = req_src2;
          op_d    = req_op;
          acc_d   = 64'h0;
          pass_d  = 2'd0;
          wait_d  = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wait_q == LAT) begin
          acc_d  = acc_q + partial;
          wait_d = 3'd0;
          if (pass_q == last_pass) state_d = FIX;
          else                     pass_d  = pass_q + 2'd1;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      FIX: begin
        // Unsigned product to signed: subtract the other operand for each negative signed input.
        if (a_q[31] && op_q[1])           hi_fix = hi_fix - b_q;
        if (b_q[31] && op_q == OP_MULXSS) hi_fix = hi_fix - a_q;
        acc_d        = {hi_fix, acc_q[31:0]};
        rsp_result_d = (op_q == OP_MUL) ? acc_q[31:0] : hi_fix;
        state_d      = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      pass_q       <= '0;
      wait_q       <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      pass_q       <= pass_d;
      wait_q       <= wait_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = rsp_result_q;
  assign mul_src1   = (state_q == RUN) ? {16'h0, a_half} : 32'h0;
  assign mul_src2   = (state_q == RUN) ? {16'h0, b_half} : 32'h0;

endmodule

// File: tb/tb_top_level_nios2_qsys_0_mul_seq.sv
// Directed bench: two sequencer instances (cell latency 1 and 3), each with a delayed cell model.
module tb_top_level_nios2_qsys_0_mul_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic [31:0] mul_src1  [2];
  logic [31:0] mul_src2  [2];
  logic [31:0] cell_res  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result[2];

  top_level_nios2_qsys_0_mul_seq #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_src1(req_src1[0]), .req_src2(req_src2[0]),
    .mul_src1(mul_src1[0]), .mul_src2(mul_src2[0]), .mul_cell_result(cell_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]));

  top_level_nios2_qsys_0_mul_seq #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_src1(req_src1[1]), .req_src2(req_src2[1]),
    .mul_src1(mul_src1[1]), .mul_src2(mul_src2[1]), .mul_cell_result(cell_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]));

  // Cell models: registered product delayed by 1 and 3 cycles.
  logic [31:0] c1_pipe;
  logic [31:0] c3_pipe [3];
  always @(posedge clk) begin
    c1_pipe    <= mul_src1[0] * mul_src2[0];
    c3_pipe[0] <= mul_src1[1] * mul_src2[1];
    c3_pipe[1] <= c3_pipe[0];
    c3_pipe[2] <= c3_pipe[1];
  end
  assign cell_res[0] = c1_pipe;
  assign cell_res[1] = c3_pipe[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          s;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Latency counts the accept cycle as cycle 0 and the first rsp_valid cycle as the latency.
  task automatic do_op(input int s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int cyc;
    @(negedge clk);
    req_valid[s] = 1'b1; req_op[s] = op; req_src1[s] = a; req_src2[s] = b;
    check({name, " req_ready"}, {31'h0, req_ready[s]}, 32'h1);
    @(posedge clk);
    #1 req_valid[s] = 1'b0;
    cyc = 0;
    while (!rsp_valid[s] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc + 1), 32'(lat));
    check({name, " result"}, rsp_result[s], exp);
    if (rsp_ready[s]) begin
      @(posedge clk); #1;
      check({name, " rsp_valid drop"}, {31'h0, rsp_valid[s]}, 32'h0);
    end
  endtask

  vec_t vecs[$];
  logic [31:0] held;

  initial begin
    vecs = '{
      '{0, 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 8},
      '{0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10},
      '{0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 8},
      '{0, 2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 10},
      '{0, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 10},
      '{0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 10},
      '{0, 2'b11, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 10},
      '{0, 2'b10, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 10},
      '{0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 10},
      '{0, 2'b11, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 10},
      '{0, 2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 8},
      '{1, 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 14},
      '{1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 18},
      '{1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 14},
      '{1, 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 18}
    };
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_op[s] = 2'b00; req_src1[s] = '0; req_src2[s] = '0;
      rsp_ready[s] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check("reset req_ready", {31'h0, req_ready[s]}, 32'h1);
      check("reset rsp_valid", {31'h0, rsp_valid[s]}, 32'h0);
      check("reset rsp_result", rsp_result[s], 32'h0);
      check("reset mul_src1", mul_src1[s], 32'h0);
      check("reset mul_src2", mul_src2[s], 32'h0);
    end

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
            $sformatf("vec%0d", i));

    // Backpressure: hold rsp_ready low in DONE; a stray request must be ignored.
    rsp_ready[0] = 1'b0;
    do_op(0, 2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 10, "bp");
    held = rsp_result[0];
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 2'b00; req_src1[0] = 32'h3; req_src2[0] = 32'h5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp rsp_valid held", {31'h0, rsp_valid[0]}, 32'h1);
      check("bp rsp_result held", rsp_result[0], 32'h40000000);
      check("bp req_ready low", {31'h0, req_ready[0]}, 32'h0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp handshake rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    check("bp handshake req_ready", {31'h0, req_ready[0]}, 32'h1);
    do_op(0, 2'b00, 32'h3, 32'h5, 32'h0000000F, 8, "bp next");

    // Reset during pass 2 of a high-word op drops it.
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 2'b01; req_src1[0] = 32'hFFFFFFFF; req_src2[0] = 32'hFFFFFFFF;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("rst mid pass2 mul_src1", mul_src1[0], 32'h0000FFFF);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rst mid req_ready", {31'h0, req_ready[0]}, 32'h1);
    check("rst mid rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    check("rst mid mul_src1", mul_src1[0], 32'h0);
    check("rst mid mul_src2", mul_src2[0], 32'h0);
    @(negedge clk) reset = 1'b0;
    do_op(0, 2'b01, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 10, "after rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
